eq_gain_writer: RTL and testbench

Serial gain-programming transmitter for the equalizer core (`my_eq_u1`). Accepts one (band, gain) request at a time over a valid/ready handshake and serializes it MSB-first onto the core's `gainset` line, framed by `gainwe`. It also sequences the core's `eq_rst` after power-up and on software request. Its outputs are the signals the GAO probes capture, so frames must be directly readable in the analyzer.

---
 rtl/eq_gain_writer_pkg.sv | 24 ++
 rtl/eq_gain_writer_bit_timer.sv | 28 ++
 rtl/eq_gain_writer.sv | 142 ++++++++++++++
 tb/tb_eq_gain_writer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_gain_writer_pkg.sv
// Shared types and sizing for the EQ gain writer; frame width follows EQ_GAIN_PARITY_EN.
package eq_pkg;

  localparam int unsigned EQ_NUM_BANDS = 10;
  localparam int unsigned EQ_BAND_W    = 4;
  localparam int unsigned EQ_GAIN_W    = 8;

  typedef enum logic [1:0] {
    RST,
    IDLE,
    SHIFT,
    GAP
  } eq_wr_state_t;

  function automatic int unsigned eq_frame_w(input int unsigned band_w,
                                             input int unsigned gain_w);
`ifdef EQ_GAIN_PARITY_EN
    return band_w + gain_w + 1;
`else
    return band_w + gain_w;
`endif
  endfunction

endpackage

// File: rtl/eq_gain_writer_bit_timer.sv
// Serial bit divider: bit_tick marks the last sys_clk cycle of each bit period.
module eq_bit_timer #(
  parameter int unsigned BIT_DIV = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  output logic bit_tick
);

  localparam int unsigned      DIV_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt <= '0;
    end else if (clr || (div_cnt == DIV_LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign bit_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/eq_gain_writer.sv
// Serial gain-programming transmitter and eq_rst sequencer for the EQ core.
// Build option: EQ_GAIN_PARITY_EN appends an even-parity bit to every frame.
module eq_gain_writer
  import eq_pkg::*;
#(
  parameter int unsigned NUM_BANDS  = EQ_NUM_BANDS,
  parameter int unsigned BAND_W     = EQ_BAND_W,
  parameter int unsigned GAIN_W     = EQ_GAIN_W,
  parameter int unsigned BIT_DIV    = 4,
  parameter int unsigned RST_CYCLES = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req_valid,
  input  logic [BAND_W-1:0] req_band,
  input  logic [GAIN_W-1:0] req_gain,
  output logic              req_ready,
  input  logic              soft_rst,
  output logic              gainwe,
  output logic              gainset,
  output logic              eq_rst,
  output logic              err_band,
  output logic              busy
);

  localparam int unsigned       FRAME_W  = eq_frame_w(BAND_W, GAIN_W);
  localparam int unsigned       BCNT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned       RCNT_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(FRAME_W - 1);
  localparam logic [RCNT_W-1:0] RST_LAST = RCNT_W'(RST_CYCLES - 1);

  eq_wr_state_t       state;
  logic [FRAME_W-1:0] frame;
  logic [FRAME_W-2:0] shreg;
  logic [BCNT_W-1:0]  bit_cnt;
  logic [RCNT_W-1:0]  rst_cnt;
  logic               bit_tick;
  logic               timer_clr;
  logic               band_ok;

`ifdef EQ_GAIN_PARITY_EN
  assign frame = {req_band, req_gain, ^{req_band, req_gain}};
`else
  assign frame = {req_band, req_gain};
`endif

  assign band_ok   = (32'(req_band) < NUM_BANDS);
  assign req_ready = (state == IDLE) && !soft_rst;
  // Divider only runs inside SHIFT/GAP; it wraps to 0 on the tick that changes state.
  assign timer_clr = soft_rst || !((state == SHIFT) || (state == GAP));

  eq_bit_timer #(
    .BIT_DIV (BIT_DIV)
  ) u_bit_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (timer_clr),
    .bit_tick  (bit_tick)
  );

  // shreg holds only the bits still to be sent; the current bit lives in gainset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= RST;
      shreg    <= '0;
      bit_cnt  <= '0;
      rst_cnt  <= '0;
      eq_rst   <= 1'b1;
      gainwe   <= 1'b0;
      gainset  <= 1'b0;
      err_band <= 1'b0;
      busy     <= 1'b1;
    end else begin
      err_band <= 1'b0;
      if (soft_rst) begin
        state   <= RST;
        rst_cnt <= '0;
        bit_cnt <= '0;
        eq_rst  <= 1'b1;
        gainwe  <= 1'b0;
        gainset <= 1'b0;
        busy    <= 1'b1;
      end else begin
        case (state)
          RST: begin
            if (rst_cnt == RST_LAST) begin
              state   <= IDLE;
              rst_cnt <= '0;
              eq_rst  <= 1'b0;
              busy    <= 1'b0;
            end else begin
              rst_cnt <= rst_cnt + RCNT_W'(1);
            end
          end
          IDLE: begin
            if (req_valid) begin
              if (band_ok) begin
                state   <= SHIFT;
                shreg   <= frame[FRAME_W-2:0];
                bit_cnt <= '0;
                gainwe  <= 1'b1;
                gainset <= frame[FRAME_W-1];
                busy    <= 1'b1;
              end else begin
                err_band <= 1'b1;
              end
            end
          end
          SHIFT: begin
            if (bit_tick) begin
              if (bit_cnt == BIT_LAST) begin
                state   <= GAP;
                bit_cnt <= '0;
                gainwe  <= 1'b0;
                gainset <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + BCNT_W'(1);
                gainset <= shreg[FRAME_W-2];
                shreg   <= {shreg[FRAME_W-3:0], 1'b0};
              end
            end
          end
          GAP: begin
            if (bit_tick) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state   <= RST;
            rst_cnt <= '0;
            eq_rst  <= 1'b1;
            gainwe  <= 1'b0;
            gainset <= 1'b0;
            busy    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eq_gain_writer.sv
// Bench for eq_gain_writer: per-cycle expected-waveform model plus directed literal checks.
module tb_eq_gain_writer;

  localparam int unsigned NB = 10;
  localparam int unsigned BW = 4;
  localparam int unsigned GW = 8;
  localparam int unsigned BD = 2;
  localparam int unsigned RC = 4;
`ifdef EQ_GAIN_PARITY_EN
  localparam int unsigned EXP_FW   = 13;
  localparam logic [31:0] EXP_BITS = 32'h0000_074A;
`else
  localparam int unsigned EXP_FW   = 12;
  localparam logic [31:0] EXP_BITS = 32'h0000_03A5;
`endif

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          soft_rst  = 1'b0;
  logic [BW-1:0] req_band  = '0;
  logic [GW-1:0] req_gain  = '0;
  logic          req_ready, gainwe, gainset, eq_rst, err_band, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  eq_gain_writer #(
    .NUM_BANDS  (NB),
    .BAND_W     (BW),
    .GAIN_W     (GW),
    .BIT_DIV    (BD),
    .RST_CYCLES (RC)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req_valid (req_valid),
    .req_band  (req_band),
    .req_gain  (req_gain),
    .req_ready (req_ready),
    .soft_rst  (soft_rst),
    .gainwe    (gainwe),
    .gainset   (gainset),
    .eq_rst    (eq_rst),
    .err_band  (err_band),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining reset cycles, plus a queue of {gainwe,gainset} for every
  // cycle of the frame in flight (bits and gap). Empty queue and no reset = idle.
  logic [1:0] exp_q[$];
  int         rst_left = RC;
  logic       cur_err  = 1'b0;
  logic       m_idle;
  logic [1:0] m_cur;

  task automatic push_frame(input logic [BW-1:0] b, input logic [GW-1:0] g);
    logic [BW+GW-1:0] w;
    w = {b, g};
    for (int i = BW + GW - 1; i >= 0; i--) begin
      repeat (BD) exp_q.push_back({1'b1, w[i]});
    end
`ifdef EQ_GAIN_PARITY_EN
    repeat (BD) exp_q.push_back({1'b1, ^w});
`endif
    repeat (BD) exp_q.push_back(2'b00);
  endtask

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      rst_left = RC;
      exp_q.delete();
      cur_err = 1'b0;
      chk("reset eq_rst", eq_rst, 1'b1);
      chk("reset gainwe", gainwe, 1'b0);
      chk("reset gainset", gainset, 1'b0);
      chk("reset req_ready", req_ready, 1'b0);
      chk("reset err_band", err_band, 1'b0);
      chk("reset busy", busy, 1'b1);
    end else begin
      m_idle = (rst_left == 0) && (exp_q.size() == 0);
      m_cur  = ((rst_left == 0) && (exp_q.size() != 0)) ? exp_q[0] : 2'b00;
      chk("eq_rst", eq_rst, rst_left != 0);
      chk("gainwe", gainwe, m_cur[1]);
      chk("gainset", gainset, m_cur[0]);
      chk("req_ready", req_ready, m_idle && !soft_rst);
      chk("busy", busy, !m_idle);
      chk("err_band", err_band, cur_err);
      cur_err = 1'b0;
      if (soft_rst) begin
        rst_left = RC;
        exp_q.delete();
      end else if (rst_left != 0) begin
        rst_left--;
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end else if (req_valid) begin
        if (int'(req_band) < NB) push_frame(req_band, req_gain);
        else cur_err = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_ready(input int max_cyc);
    int k;
    k = 0;
    @(negedge sys_clk);
    while (!req_ready && k < max_cyc) begin
      k++;
      @(negedge sys_clk);
    end
    chk("wait_ready", req_ready, 1'b1);
  endtask

  initial begin
    int          cnt;
    int          k;
    int          we;
    int          gap;
    logic [31:0] bits;

    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // Reset release length and ready alignment
    cnt = 0;
    k   = 0;
    @(negedge sys_clk);
    while (eq_rst && k < 50) begin
      cnt++;
      k++;
      @(negedge sys_clk);
    end
    chk_int("reset_len", cnt, RC);
    chk("ready_at_rst_fall", req_ready, 1'b1);
    tick();

    // Band 3, gain 0xA5: capture serial bits and strobe length
    req_valid = 1'b1;
    req_band  = 4'd3;
    req_gain  = 8'hA5;
    tick();
    req_valid = 1'b0;
    we   = 0;
    bits = '0;
    k    = 0;
    @(negedge sys_clk);
    while (k < 200) begin
      if (gainwe) begin
        if (we % BD == 0) bits = {bits[30:0], gainset};
        we++;
      end else if (we > 0) begin
        break;
      end
      k++;
      @(negedge sys_clk);
    end
    chk_int("we_len", we, EXP_FW * BD);
    chk_int("frame_bits", int'(bits), int'(EXP_BITS));
    gap = 0;
    while (!req_ready && gap < 50) begin
      gap++;
      @(negedge sys_clk);
    end
    chk_int("gap_len", gap, BD);
    tick();

    // Illegal band followed immediately by a legal one
    req_valid = 1'b1;
    req_band  = 4'd12;
    req_gain  = 8'h5A;
    tick();
    req_band  = 4'd5;
    req_gain  = 8'h3C;
    @(negedge sys_clk);
    chk("illegal err_band", err_band, 1'b1);
    chk("illegal ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    @(negedge sys_clk);
    chk("legal_after_illegal gainwe", gainwe, 1'b1);
    wait_ready(100);
    tick();

    // soft_rst during bit 5 aborts the frame
    req_valid = 1'b1;
    req_band  = 4'd9;
    req_gain  = 8'hF0;
    tick();
    req_valid = 1'b0;
    repeat (5 * BD) tick();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    @(negedge sys_clk);
    chk("abort gainwe", gainwe, 1'b0);
    chk("abort eq_rst", eq_rst, 1'b1);
    cnt = 1;
    k   = 0;
    @(negedge sys_clk);
    while (eq_rst && k < 50) begin
      cnt++;
      k++;
      @(negedge sys_clk);
    end
    chk_int("abort_rst_len", cnt, RC);
    tick();

    // soft_rst and req_valid together: reset wins, request accepted afterwards
    soft_rst  = 1'b1;
    req_valid = 1'b1;
    req_band  = 4'd7;
    req_gain  = 8'h11;
    tick();
    soft_rst = 1'b0;
    @(negedge sys_clk);
    chk("collide eq_rst", eq_rst, 1'b1);
    chk("collide gainwe", gainwe, 1'b0);
    wait_ready(50);
    tick();
    req_valid = 1'b0;
    @(negedge sys_clk);
    chk("collide later accept", gainwe, 1'b1);
    wait_ready(100);
    tick();

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      soft_rst  = ($urandom_range(0, 40) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_band  = BW'($urandom_range(0, 15));
      req_gain  = GW'($urandom);
      tick();
    end
    soft_rst  = 1'b0;
    req_valid = 1'b0;
    repeat (80) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
